// File: rtl/timer_pkg.sv
// Shared definitions for the timer access scheduler: FSM encoding,
// timer data width and a counter-width helper.
package timer_pkg;

  localparam int TIMER_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GRANT    = 3'd1,
    ST_RUN      = 3'd2,
    ST_WAIT_CAP = 3'd3,
    ST_RESP     = 3'd4,
    ST_CLEAR    = 3'd5
  } state_e;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or
// after the pointer (wrapping) and returns it one-hot plus as an index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  // Scan requesters starting at the pointer; first hit wins.
  always_comb begin
    logic [ID_W-1:0] cand;
    logic            found;
    cand  = '0;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = ID_W'((int'(ptr_i) + off) % N_REQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end else begin
        found = found;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/timer_access_scheduler.sv
// Shares one timer among N_REQ requesters. Grants ownership round-robin,
// converts owner start/stop events into single-cycle timer pulses, waits
// out the capture latency, returns the count (or a timeout) over a
// valid/ready channel and finally clears the timer capture.
module timer_access_scheduler
  import timer_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int CAPTURE_LAT = 3,
  parameter int TIMEOUT     = 65535
) (
  input  logic                     clk_in,
  input  logic                     rst_an_in,
  input  logic [N_REQ-1:0]         req_i,
  output logic [N_REQ-1:0]         gnt_o,
  input  logic [N_REQ-1:0]         start_evt_i,
  input  logic [N_REQ-1:0]         stop_evt_i,
  output logic                     timer_start_o,
  output logic                     timer_capture_o,
  output logic                     timer_rst_capture_o,
  input  logic [TIMER_W-1:0]       timer_captured_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [$clog2(N_REQ)-1:0] rsp_id_o,
  output logic [TIMER_W-1:0]       rsp_data_o,
  output logic                     rsp_timeout_o,
  output logic                     busy_o
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam int LAT_W = cnt_width(CAPTURE_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [LAT_W-1:0] LAT_VAL = LAT_W'(CAPTURE_LAT);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);
  localparam bit               TO_EN   = (TIMEOUT != 0);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [CNT_W-1:0]     to_cnt_q, to_cnt_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic                 start_q, start_d;
  logic                 cap_q, cap_d;
  logic                 rstcap_q, rstcap_d;
  logic                 valid_q, valid_d;
  logic [TIMER_W-1:0]   data_q, data_d;
  logic                 to_q, to_d;
  logic                 busy_q;

  logic [N_REQ-1:0]     arb_gnt_s;
  logic [ID_W-1:0]      arb_idx_s;
  logic                 arb_any_s;
  logic [CNT_W-1:0]     to_inc_s;
  logic                 own_req_s;
  logic                 own_start_s;
  logic                 own_stop_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt_s),
    .idx_o (arb_idx_s),
    .any_o (arb_any_s)
  );

  // Only the current owner's lines matter; everything else is dropped.
  assign own_req_s   = req_i[owner_q];
  assign own_start_s = start_evt_i[owner_q];
  assign own_stop_s  = stop_evt_i[owner_q];

  // Saturating increment of the RUN-phase timeout counter.
  assign to_inc_s = (to_cnt_q == CNT_MAX) ? to_cnt_q : to_cnt_q + 1'b1;

  // Next-state logic; timer pulses default low so each lasts one cycle.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    to_cnt_d = to_cnt_q;
    lat_d    = lat_q;
    start_d  = 1'b0;
    cap_d    = 1'b0;
    rstcap_d = 1'b0;
    valid_d  = valid_q;
    data_d   = data_q;
    to_d     = to_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any_s) begin
          owner_d = arb_idx_s;
          gnt_d   = arb_gnt_s;
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // Start has priority over a same-cycle stop or a request drop.
        if (own_start_s) begin
          start_d  = 1'b1;
          to_cnt_d = '0;
          state_d  = ST_RUN;
        end else if (!own_req_s) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_GRANT;
        end
      end
      ST_RUN: begin
        to_cnt_d = to_inc_s;
        if (own_stop_s) begin
          cap_d   = 1'b1;
          lat_d   = '0;
          state_d = ST_WAIT_CAP;
        end else if (TO_EN && (to_inc_s == TO_VAL)) begin
          valid_d = 1'b1;
          data_d  = '0;
          to_d    = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WAIT_CAP: begin
        if (lat_q == LAT_VAL) begin
          data_d  = timer_captured_i;
          to_d    = 1'b0;
          valid_d = 1'b1;
          state_d = ST_RESP;
        end else begin
          lat_d   = lat_q + 1'b1;
          state_d = ST_WAIT_CAP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          valid_d = 1'b0;
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_CLEAR: begin
        rstcap_d = 1'b1;
        gnt_d    = '0;
        ptr_d    = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction silently.
  always_ff @(posedge clk_in or negedge rst_an_in) begin
    if (!rst_an_in) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      gnt_q    <= '0;
      to_cnt_q <= '0;
      lat_q    <= '0;
      start_q  <= 1'b0;
      cap_q    <= 1'b0;
      rstcap_q <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      to_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      to_cnt_q <= to_cnt_d;
      lat_q    <= lat_d;
      start_q  <= start_d;
      cap_q    <= cap_d;
      rstcap_q <= rstcap_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      to_q     <= to_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign gnt_o               = gnt_q;
  assign timer_start_o       = start_q;
  assign timer_capture_o     = cap_q;
  assign timer_rst_capture_o = rstcap_q;
  assign rsp_valid_o         = valid_q;
  assign rsp_id_o            = owner_q;
  assign rsp_data_o          = data_q;
  assign rsp_timeout_o       = to_q;
  assign busy_o              = busy_q;

endmodule
